ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 21 ++
 rtl/ram_arbiter.sv | 61 ++++++
 tb/tb_ram_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and RAM-port bundle for ram_arbiter
// slave modport: arbiter side (takes requests and ram_doutb, drives grants, read returns and RAM ports)
// master modport: environment side (requesters plus RAM model)
interface ram_arbiter_if #(parameter int AW = 6, parameter int DW = 32);
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_wea;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_doutb,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_wea, ram_addra, ram_dina, ram_addrb
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_doutb,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_wea, ram_addra, ram_dina, ram_addrb
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin front end for a dual-port RAM, with a zero-fill INIT sweep
// clk/rst_n: clock and async active-low reset; clr: re-zero request; init_done: RAM cleared, serving
// bus: requester ports (req/we/addr/wdata in, gnt/rvalid/rdata out) and RAM ports A (write) / B (read)
module ram_arbiter #(parameter int AW = 6, parameter int DW = 32) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  output logic        init_done,
  ram_arbiter_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;
  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_last, r_rvalid0, r_rvalid1;
  logic          w_run, w_g0, w_g1, w_we, w_wr, w_rd;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  // requester 0 wins a tie when last == 1, requester 1 when last == 0
  always_comb begin
    w_run   = r_state == RUN;
    w_g0    = w_run && !clr && bus.req0 && (!bus.req1 || r_last);
    w_g1    = w_run && !clr && bus.req1 && (!bus.req0 || !r_last);
    w_we    = w_g0 ? bus.we0 : bus.we1;
    w_addr  = w_g0 ? bus.addr0 : bus.addr1;
    w_wdata = w_g0 ? bus.wdata0 : bus.wdata1;
    w_wr    = (w_g0 || w_g1) && w_we;
    w_rd    = (w_g0 || w_g1) && !w_we;
  end
  assign init_done     = w_run;
  assign bus.gnt0      = w_g0;
  assign bus.gnt1      = w_g1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = bus.ram_doutb;
  assign bus.rdata1    = bus.ram_doutb;
  // port A is owned by the zero-fill sweep during INIT
  assign bus.ram_wea   = !w_run || w_wr;
  assign bus.ram_addra = !w_run ? r_cnt : w_wr ? w_addr : '0;
  assign bus.ram_dina  = w_wr ? w_wdata : '0;
  assign bus.ram_addrb = w_rd ? w_addr : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INIT;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_g0 && !bus.we0;
      r_rvalid1 <= w_g1 && !bus.we1;
      if (w_g0 || w_g1) r_last <= w_g1;
      if (!w_run) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '1) r_state <= RUN;
      end else if (clr) begin
        r_cnt   <= '0;
        r_state <= INIT;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a behavioural model and RAM
module tb_ram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic init_done;
  ram_arbiter_if #(.AW(6), .DW(32)) bus();
  ram_arbiter #(.AW(6), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .clr(clr), .init_done(init_done), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
    bus.ram_doutb <= mem[bus.ram_addrb];
  end
  int n_assert = 0, n_fail = 0;
  bit q0, q1, w0, w1, c;
  logic [5:0] a0, a1;
  logic [31:0] d0, d1;
  logic [31:0] ref_mem [64];
  int m_left, m_win;
  bit m_last, e_rv0, e_rv1;
  logic [31:0] e_rd;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_left = 64; m_last = 1'b1; e_rv0 = 1'b0; e_rv1 = 1'b0; m_win = -1;
  endtask
  task automatic cycle();
    bit init, wr;
    logic [5:0] a;
    logic [31:0] d;
    bus.req0 = q0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = q1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    clr = c;
    #1;
    init = m_left > 0;
    m_win = -1;
    if (!init && !c) m_win = (q0 && q1) ? 1 - int'(m_last) : q0 ? 0 : q1 ? 1 : -1;
    wr = m_win == 0 ? w0 : m_win == 1 ? w1 : 1'b0;
    a = m_win == 1 ? a1 : a0;
    d = m_win == 1 ? d1 : d0;
    chk("gnt0", 32'(bus.gnt0), 32'(m_win == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(m_win == 1));
    chk("init_done", 32'(init_done), 32'(!init));
    chk("ram_wea", 32'(bus.ram_wea), 32'(init || wr));
    chk("ram_addra", 32'(bus.ram_addra), init ? 32'(64 - m_left) : wr ? 32'(a) : 32'd0);
    chk("ram_dina", bus.ram_dina, (!init && wr) ? d : 32'd0);
    chk("ram_addrb", 32'(bus.ram_addrb), (m_win >= 0 && !wr) ? 32'(a) : 32'd0);
    chk("rvalid0", 32'(bus.rvalid0), 32'(e_rv0));
    chk("rvalid1", 32'(bus.rvalid1), 32'(e_rv1));
    if (e_rv0) chk("rdata0", bus.rdata0, e_rd);
    if (e_rv1) chk("rdata1", bus.rdata1, e_rd);
    e_rv0 = m_win == 0 && !wr;
    e_rv1 = m_win == 1 && !wr;
    if (m_win >= 0 && !wr) e_rd = ref_mem[a];
    if (wr) ref_mem[a] = d;
    if (m_win >= 0) m_last = m_win[0];
    if (init) begin
      ref_mem[64 - m_left] = 32'd0;
      m_left--;
    end else if (c) m_left = 64;
    @(negedge clk);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    model_reset();
    q0 = 1; w0 = 0; a0 = 6'd63; d0 = 0;
    q1 = 1; w1 = 0; a1 = 6'd10; d1 = 0;
    #2;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(64);
    cycle();
    q0 = 0; cycle();
    q1 = 0; cycle();
    q0 = 1; w0 = 1; a0 = 6'd5; d0 = 32'hDEADBEEF; cycle();
    w0 = 0; cycle();
    q0 = 0; cycle();
    q1 = 1; w1 = 1; a1 = 6'd7; d1 = 32'h12345678; cycle();
    w1 = 0; q0 = 1; run(4);
    q0 = 0; q1 = 0; cycle();
    q0 = 1; cycle();
    q0 = 0; q1 = 1; c = 1; cycle();
    c = 0; run(64);
    q1 = 0; q0 = 1; cycle();
    q0 = 0; cycle();
    q1 = 1; cycle();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstpend_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rstpend_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rstpend_init_done", 32'(init_done), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    q1 = 0;
    run(64);
    for (int i = 0; i < 600; i++) begin
      c = $urandom_range(99) == 0;
      cycle();
      if (m_win == 0 || !q0) begin
        q0 = $urandom_range(1); w0 = $urandom_range(1); a0 = 6'($urandom_range(7)); d0 = $urandom;
      end
      if (m_win == 1 || !q1) begin
        q1 = $urandom_range(1); w1 = $urandom_range(1); a1 = 6'($urandom_range(7)); d1 = $urandom;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
